// File: rtl/palindrome_scan_if.sv
// Command/status bundle for palindrome_scan_core.
// The irq wire exists only when PALINDROME_SCAN_IRQ_EN is defined.
interface palindrome_scan_if #(
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  start;
    logic                  abort;
    logic [DATA_WIDTH-1:0] lo_val;
    logic [DATA_WIDTH-1:0] hi_val;
    logic [5:0]            nbits;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [DATA_WIDTH-1:0] pal_count;
    logic [DATA_WIDTH-1:0] last_pal;
    logic [DATA_WIDTH-1:0] cur_val;
`ifdef PALINDROME_SCAN_IRQ_EN
    logic                  irq;
`endif

    modport master (
        output start, abort, lo_val, hi_val, nbits,
        input  busy, done, err, pal_count, last_pal, cur_val
`ifdef PALINDROME_SCAN_IRQ_EN
        , input irq
`endif
    );

    modport slave (
        input  start, abort, lo_val, hi_val, nbits,
        output busy, done, err, pal_count, last_pal, cur_val
`ifdef PALINDROME_SCAN_IRQ_EN
        , output irq
`endif
    );
endinterface

// File: rtl/palindrome_scan_core.sv
// Scans [lo_val, hi_val] one value per cycle, counting N-bit bit-palindromes.
// Optional one-cycle completion interrupt: define PALINDROME_SCAN_IRQ_EN.
module palindrome_scan_core #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    palindrome_scan_if.slave  bus
);
    localparam int unsigned NW = $clog2(DATA_WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SCAN = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic [DATA_WIDTH-1:0] cur_q, cur_d;
    logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] last_q, last_d;
    logic [NW-1:0]         n_q, n_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  irq_d;

    logic [DATA_WIDTH-1:0] rev_c;
    logic [NW-1:0]         shift_c;
    logic                  is_pal_c;
    logic [NW-1:0]         n_eff_c;

    // Reversing the whole word and shifting right by (W-N) yields the reversed
    // low N bits with zeros above, so one compare also rejects high bits.
    always_comb begin
        for (int i = 0; i < DATA_WIDTH; i++) begin
            rev_c[i] = cur_q[DATA_WIDTH-1-i];
        end
        shift_c  = NW'(DATA_WIDTH) - n_q;
        is_pal_c = (cur_q == (rev_c >> shift_c));
        n_eff_c  = ((bus.nbits == 6'd0) || (32'(bus.nbits) > DATA_WIDTH))
                   ? NW'(DATA_WIDTH) : NW'(bus.nbits);
    end

    // Next-state and next-output logic
    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        cur_d   = cur_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        n_d     = n_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        irq_d   = 1'b0;

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    hi_d   = bus.hi_val;
                    n_d    = n_eff_c;
                    cur_d  = bus.lo_val;
                    cnt_d  = '0;
                    last_d = '0;
                    if (bus.lo_val > bus.hi_val) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        irq_d   = 1'b1;
                    end else begin
                        state_d = SCAN;
                        busy_d  = 1'b1;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                    end
                end
            end
            SCAN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b0;
                end else begin
                    if (is_pal_c) begin
                        cnt_d  = cnt_q + DATA_WIDTH'(1);
                        last_d = cur_q;
                    end
                    // Equality-only termination: hi = all-ones never wraps.
                    if (cur_q == hi_q) begin
                        state_d = DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        irq_d   = 1'b1;
                    end else begin
                        cur_d = cur_q + DATA_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= IDLE;
            hi_q    <= '0;
            cur_q   <= '0;
            cnt_q   <= '0;
            last_q  <= '0;
            n_q     <= NW'(DATA_WIDTH);
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            cur_q   <= cur_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            n_q     <= n_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

`ifdef PALINDROME_SCAN_IRQ_EN
    logic irq_q;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign bus.irq = irq_q;
`else
    // Without the interrupt option the entry strobe has no consumer.
    logic unused_irq_c;
    assign unused_irq_c = irq_d;
`endif

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    assign bus.pal_count = cnt_q;
    assign bus.last_pal  = last_q;
    assign bus.cur_val   = cur_q;
endmodule

// File: tb/tb_palindrome_scan_core.sv
// Directed bench for palindrome_scan_core; checks the irq pulse only when
// PALINDROME_SCAN_IRQ_EN is defined.
module tb_palindrome_scan_core;
    localparam int unsigned DW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;

    palindrome_scan_if #(.DATA_WIDTH(DW)) bus ();

    palindrome_scan_core #(.DATA_WIDTH(DW)) dut (
        .ACLK    (clk),
        .ARESETN (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Raise start for exactly one edge; returns just after that edge.
    task automatic pulse_start(input logic [DW-1:0] lo, input logic [DW-1:0] hi,
                               input logic [5:0] nb, input logic ab);
        bus.lo_val = lo;
        bus.hi_val = hi;
        bus.nbits  = nb;
        bus.start  = 1'b1;
        bus.abort  = ab;
        tick();
        bus.start  = 1'b0;
        bus.abort  = 1'b0;
    endtask

    // cyc counts edges since the edge before start was raised.
    task automatic wait_done(input int budget, output int cyc, output bit timeout);
        cyc = 1;
        while (!bus.done && cyc < budget) begin
            tick();
            cyc++;
        end
        timeout = !bus.done;
    endtask

    task automatic test_reset();
        bus.start = 1'b0; bus.abort = 1'b0;
        bus.lo_val = '0; bus.hi_val = '0; bus.nbits = '0;
        #12;
        vectors++; if ({bus.busy, bus.done, bus.err} !== 3'b000) begin miscompares++; $display("FAIL reset_flags: got %b expected 000", {bus.busy, bus.done, bus.err}); end
        vectors++; if (bus.pal_count !== 32'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", bus.pal_count); end
        vectors++; if ({bus.last_pal, bus.cur_val} !== 64'd0) begin miscompares++; $display("FAIL reset_vals: got %h expected 0", {bus.last_pal, bus.cur_val}); end
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_basic_nbits4();
        int cyc; bit to;
        pulse_start(32'd0, 32'd15, 6'd4, 1'b0);
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy: got %b expected 1", bus.busy); end
        vectors++; if (bus.cur_val !== 32'd0) begin miscompares++; $display("FAIL basic_cur_load: got %0d expected 0", bus.cur_val); end
        wait_done(40, cyc, to);
        vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL basic_timeout: got %b expected 0", to); end
        vectors++; if (cyc !== 17) begin miscompares++; $display("FAIL basic_latency: got %0d expected 17", cyc); end
        vectors++; if (bus.pal_count !== 32'd4) begin miscompares++; $display("FAIL basic_count: got %0d expected 4", bus.pal_count); end
        vectors++; if (bus.last_pal !== 32'd15) begin miscompares++; $display("FAIL basic_last: got %0d expected 15", bus.last_pal); end
        vectors++; if ({bus.busy, bus.err} !== 2'b00) begin miscompares++; $display("FAIL basic_busy_err: got %b expected 00", {bus.busy, bus.err}); end
`ifdef PALINDROME_SCAN_IRQ_EN
        vectors++; if (bus.irq !== 1'b1) begin miscompares++; $display("FAIL basic_irq_on: got %b expected 1", bus.irq); end
`endif
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
`ifdef PALINDROME_SCAN_IRQ_EN
        vectors++; if (bus.irq !== 1'b0) begin miscompares++; $display("FAIL basic_irq_off: got %b expected 0", bus.irq); end
`endif
        tick();
        vectors++; if ({bus.done, bus.busy} !== 2'b10) begin miscompares++; $display("FAIL done_hold_abort: got %b expected 10", {bus.done, bus.busy}); end
        vectors++; if (bus.pal_count !== 32'd4) begin miscompares++; $display("FAIL done_hold_count: got %0d expected 4", bus.pal_count); end
    endtask

    task automatic test_upper_bits();
        int cyc; bit to;
        pulse_start(32'h81, 32'h81, 6'd8, 1'b0);
        wait_done(10, cyc, to);
        vectors++; if (cyc !== 2) begin miscompares++; $display("FAIL single_latency: got %0d expected 2", cyc); end
        vectors++; if (bus.pal_count !== 32'd1) begin miscompares++; $display("FAIL single_count: got %0d expected 1", bus.pal_count); end
        vectors++; if (bus.last_pal !== 32'h81) begin miscompares++; $display("FAIL single_last: got %h expected 81", bus.last_pal); end
        pulse_start(32'h181, 32'h181, 6'd8, 1'b0);
        wait_done(10, cyc, to);
        vectors++; if (to !== 1'b0) begin miscompares++; $display("FAIL upper_timeout: got %b expected 0", to); end
        vectors++; if (bus.pal_count !== 32'd0) begin miscompares++; $display("FAIL upper_count: got %0d expected 0", bus.pal_count); end
        vectors++; if (bus.last_pal !== 32'd0) begin miscompares++; $display("FAIL upper_last: got %h expected 0", bus.last_pal); end
    endtask

    task automatic test_err();
        int busy_seen;
        int irq_pulses;
        pulse_start(32'd10, 32'd5, 6'd0, 1'b0);
        busy_seen = int'(bus.busy);
        irq_pulses = 0;
`ifdef PALINDROME_SCAN_IRQ_EN
        irq_pulses = int'(bus.irq);
`endif
        vectors++; if ({bus.err, bus.done} !== 2'b11) begin miscompares++; $display("FAIL err_flags: got %b expected 11", {bus.err, bus.done}); end
        vectors++; if (bus.pal_count !== 32'd0) begin miscompares++; $display("FAIL err_count: got %0d expected 0", bus.pal_count); end
        vectors++; if (bus.cur_val !== 32'd10) begin miscompares++; $display("FAIL err_cur: got %0d expected 10", bus.cur_val); end
        for (int i = 0; i < 4; i++) begin
            tick();
            busy_seen += int'(bus.busy);
`ifdef PALINDROME_SCAN_IRQ_EN
            irq_pulses += int'(bus.irq);
`endif
        end
        vectors++; if (busy_seen !== 0) begin miscompares++; $display("FAIL err_busy_seen: got %0d expected 0", busy_seen); end
`ifdef PALINDROME_SCAN_IRQ_EN
        vectors++; if (irq_pulses !== 1) begin miscompares++; $display("FAIL err_irq_pulses: got %0d expected 1", irq_pulses); end
`endif
    endtask

    task automatic test_no_wrap();
        int cyc; bit to;
        pulse_start(32'hFFFF_FFF0, 32'hFFFF_FFFF, 6'd0, 1'b0);
        wait_done(40, cyc, to);
        vectors++; if (cyc !== 17) begin miscompares++; $display("FAIL wrap_latency: got %0d expected 17", cyc); end
        vectors++; if (bus.pal_count !== 32'd1) begin miscompares++; $display("FAIL wrap_count: got %0d expected 1", bus.pal_count); end
        vectors++; if (bus.last_pal !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL wrap_last: got %h expected ffffffff", bus.last_pal); end
        vectors++; if (bus.cur_val !== 32'hFFFF_FFFF) begin miscompares++; $display("FAIL wrap_cur: got %h expected ffffffff", bus.cur_val); end
        repeat (3) tick();
        vectors++; if ({bus.done, bus.cur_val} !== {1'b1, 32'hFFFF_FFFF}) begin miscompares++; $display("FAIL wrap_hold: got %h expected 1ffffffff", {bus.done, bus.cur_val}); end
    endtask

    task automatic test_start_ignored();
        int cyc; bit to;
        pulse_start(32'd0, 32'd15, 6'd4, 1'b0);
        repeat (3) tick();
        pulse_start(32'd100, 32'd50, 6'd8, 1'b0);
        vectors++; if ({bus.busy, bus.err} !== 2'b10) begin miscompares++; $display("FAIL ignored_flags: got %b expected 10", {bus.busy, bus.err}); end
        wait_done(40, cyc, to);
        vectors++; if ({to, bus.err} !== 2'b00) begin miscompares++; $display("FAIL ignored_end: got %b expected 00", {to, bus.err}); end
        vectors++; if (bus.pal_count !== 32'd4) begin miscompares++; $display("FAIL ignored_count: got %0d expected 4", bus.pal_count); end
    endtask

    task automatic test_abort_restart();
        int cyc; bit to;
        pulse_start(32'd0, 32'd255, 6'd8, 1'b0);
        repeat (9) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        vectors++; if ({bus.busy, bus.done} !== 2'b00) begin miscompares++; $display("FAIL abort_flags: got %b expected 00", {bus.busy, bus.done}); end
        vectors++; if (bus.pal_count !== 32'd1) begin miscompares++; $display("FAIL abort_count: got %0d expected 1", bus.pal_count); end
        vectors++; if (bus.cur_val !== 32'd9) begin miscompares++; $display("FAIL abort_cur: got %0d expected 9", bus.cur_val); end
        repeat (3) tick();
        vectors++; if ({bus.busy, bus.done, bus.cur_val} !== {2'b00, 32'd9}) begin miscompares++; $display("FAIL abort_idle_hold: got %h expected 9", {bus.busy, bus.done, bus.cur_val}); end
        pulse_start(32'd0, 32'd255, 6'd8, 1'b1);
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL restart_start_wins: got %b expected 1", bus.busy); end
        wait_done(300, cyc, to);
        vectors++; if (cyc !== 257) begin miscompares++; $display("FAIL restart_latency: got %0d expected 257", cyc); end
        vectors++; if (bus.pal_count !== 32'd16) begin miscompares++; $display("FAIL restart_count: got %0d expected 16", bus.pal_count); end
        vectors++; if (bus.last_pal !== 32'd255) begin miscompares++; $display("FAIL restart_last: got %0d expected 255", bus.last_pal); end
    endtask

    task automatic test_reset_mid_scan();
        int cyc; bit to;
        int seen;
        pulse_start(32'd0, 32'd255, 6'd8, 1'b0);
        repeat (20) tick();
        vectors++; if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL midrst_pre_busy: got %b expected 1", bus.busy); end
        #2;
        rst_n = 1'b0;
        #1;
        vectors++; if ({bus.busy, bus.done, bus.err} !== 3'b000) begin miscompares++; $display("FAIL midrst_flags: got %b expected 000", {bus.busy, bus.done, bus.err}); end
        vectors++; if ({bus.pal_count, bus.last_pal, bus.cur_val} !== 96'd0) begin miscompares++; $display("FAIL midrst_vals: got %h expected 0", {bus.pal_count, bus.last_pal, bus.cur_val}); end
`ifdef PALINDROME_SCAN_IRQ_EN
        vectors++; if (bus.irq !== 1'b0) begin miscompares++; $display("FAIL midrst_irq: got %b expected 0", bus.irq); end
`endif
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 300; i++) begin
            tick();
            seen += int'(bus.done) + int'(bus.busy);
        end
        vectors++; if (seen !== 0) begin miscompares++; $display("FAIL midrst_no_done: got %0d expected 0", seen); end
        pulse_start(32'h81, 32'h81, 6'd8, 1'b0);
        wait_done(10, cyc, to);
        vectors++; if ({to, bus.pal_count} !== {1'b0, 32'd1}) begin miscompares++; $display("FAIL midrst_restart: got %h expected 1", {to, bus.pal_count}); end
    endtask

    initial begin
        test_reset();
        test_basic_nbits4();
        test_upper_bits();
        test_err();
        test_no_wrap();
        test_start_ignored();
        test_abort_restart();
        test_reset_mid_scan();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
